// File: rtl/seq_pkg.sv
// seq_pkg: shared types for the control sequencer
// state encoding, opcode map and class decode
package seq_pkg;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LD, C_ST, C_MD, C_BR,
    C_JR, C_IN, C_OUT, C_NOP, C_HALT, C_ILL
  } cls_t;

  localparam logic [31:0] OP_ADD   = 32'd0;
  localparam logic [31:0] OP_R_MAX = 32'd10;
  localparam logic [31:0] OP_ADDI  = 32'd11;
  localparam logic [31:0] OP_ANDI  = 32'd12;
  localparam logic [31:0] OP_ORI   = 32'd13;
  localparam logic [31:0] OP_LD    = 32'd14;
  localparam logic [31:0] OP_ST    = 32'd15;
  localparam logic [31:0] OP_MUL   = 32'd16;
  localparam logic [31:0] OP_DIV   = 32'd17;
  localparam logic [31:0] OP_BR    = 32'd18;
  localparam logic [31:0] OP_JR    = 32'd19;
  localparam logic [31:0] OP_IN    = 32'd20;
  localparam logic [31:0] OP_OUT   = 32'd21;
  localparam logic [31:0] OP_NOP   = 32'd22;
  localparam logic [31:0] OP_HALT  = 32'd23;

  function automatic cls_t decode_class(
    input logic [31:0] op
  );
    cls_t c;
    c = C_ILL;
    if (op <= OP_R_MAX) c = C_R;
    else if (op >= OP_ADDI && op <= OP_ORI) c = C_I;
    else if (op == OP_LD) c = C_LD;
    else if (op == OP_ST) c = C_ST;
    else if (op == OP_MUL || op == OP_DIV) c = C_MD;
    else if (op == OP_BR) c = C_BR;
    else if (op == OP_JR) c = C_JR;
    else if (op == OP_IN) c = C_IN;
    else if (op == OP_OUT) c = C_OUT;
    else if (op == OP_NOP) c = C_NOP;
    else if (op == OP_HALT) c = C_HALT;
    return c;
  endfunction

  // last execute step of each class
  function automatic state_t last_state(
    input cls_t c
  );
    state_t s;
    case (c)
      C_R, C_I: s = S_T5;
      C_LD, C_ST: s = S_T7;
      C_MD, C_BR: s = S_T6;
      C_JR, C_IN, C_OUT: s = S_T3;
      default: s = S_T2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// seq_decode: opcode field extraction
// and instruction class lookup
module seq_decode
  import seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPCODE_W = 5
)(
  input  logic [DATA_W-1:0]   ir,
  output logic [OPCODE_W-1:0] op,
  output cls_t                cls
);

  logic unused_ir;

  assign op = ir[DATA_W-1 -: OPCODE_W];
  assign cls = decode_class(32'(op));
  assign unused_ir = ^ir[DATA_W-OPCODE_W-1:0];

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-state control
// unit with memory wait timeout and retire count
module control_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPCODE_W = 5,
  parameter int WAIT_MAX = 15
)(
  input  logic                Clock,
  input  logic                clear,
  input  logic [DATA_W-1:0]   IR,
  input  logic                CON_FF,
  input  logic                mem_ready,
  input  logic                start,
  input  logic                stop,
  output logic                PCout,
  output logic                MARin,
  output logic                MDRin,
  output logic                Read,
  output logic                Write,
  output logic                MDRout,
  output logic                IRin,
  output logic                PCin,
  output logic                IncPC,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                Cout,
  output logic                HIin,
  output logic                LOin,
  output logic                CONin,
  output logic                Inportout,
  output logic                Outportin,
  output logic [OPCODE_W-1:0] opcode,
  output logic                run,
  output logic                illegal,
  output logic                mem_err,
  output logic [DATA_W-1:0]   instr_retired
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_t              state;
  state_t              next;
  cls_t                cls;
  logic [OPCODE_W-1:0] op;
  logic [CW-1:0]       wait_cnt;
  logic                stop_q;
  logic                mem_wait;
  logic                adv;
  logic                timeout;
  logic                retire;
  logic                expired;
  logic                halt_req;

  seq_decode #(
    .DATA_W  (DATA_W),
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .ir (IR),
    .op (op),
    .cls(cls)
  );

  assign run = (state != S_RESET)
            && (state != S_HALT);
  assign expired = !mem_ready
    && (wait_cnt == CW'(WAIT_MAX - 1));
  assign halt_req = stop || stop_q
                 || (cls == C_HALT);

  // next state and strobes from registered state
  always_comb begin
    next = state;
    {PCout, MARin, MDRin, Read, Write,
     MDRout, IRin, PCin, IncPC, Gra,
     Grb, Grc, Rin, Rout, BAout,
     Yin, Zin, Zlowout, Zhighout, Cout,
     HIin, LOin, CONin, Inportout,
     Outportin} = 25'b0;
    opcode   = OPCODE_W'(OP_ADD);
    illegal  = 1'b0;
    mem_wait = 1'b0;
    adv      = 1'b0;
    timeout  = 1'b0;
    retire   = 1'b0;
    unique case (state)
      S_RESET: next = S_T0;
      S_HALT: begin
        if (start && !stop) next = S_T0;
      end
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
      end
      S_T1: begin
        Read     = 1'b1;
        MDRin    = 1'b1;
        mem_wait = 1'b1;
        PCin     = mem_ready;
        IncPC    = mem_ready;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        illegal = (cls == C_ILL);
      end
      S_T3: begin
        case (cls)
          C_R, C_I: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end
          C_LD, C_ST: begin
            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
          end
          C_MD: begin
            Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end
          C_BR: begin
            Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
          end
          C_JR: begin
            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
          end
          C_IN: begin
            Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          C_OUT: begin
            Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_R: begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
          end
          C_I, C_LD, C_ST: begin
            Cout = 1'b1; Zin = 1'b1;
          end
          C_MD: begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
          end
          C_BR: begin
            PCout = 1'b1; Yin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_R, C_I: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          C_LD, C_ST: begin
            Zlowout = 1'b1; MARin = 1'b1;
          end
          C_MD: begin
            Zlowout = 1'b1; LOin = 1'b1;
          end
          C_BR: begin
            Cout = 1'b1; Zin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD: begin
            Read = 1'b1; MDRin = 1'b1;
            mem_wait = 1'b1;
          end
          C_ST: begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
          end
          C_MD: begin
            Zhighout = 1'b1; HIin = 1'b1;
          end
          C_BR: begin
            Zlowout = CON_FF; PCin = CON_FF;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          C_ST: begin
            Write = 1'b1;
            mem_wait = 1'b1;
          end
          default: ;
        endcase
      end
      default: next = S_RESET;
    endcase
    if (run && (state inside {S_T3, S_T4,
        S_T5, S_T6, S_T7})
        && (cls inside {C_R, C_I, C_MD}))
      opcode = op;
    if (run) begin
      adv = !mem_wait || mem_ready;
      timeout = mem_wait && expired;
      if (timeout) begin
        next = S_HALT;
      end else if (adv
          && state == last_state(cls)) begin
        next = halt_req ? S_HALT : S_T0;
        retire = (cls != C_ILL);
      end else if (adv) begin
        next = state_t'(state + 4'd1);
      end
    end
  end

  // state, wait timer, error, stop latch, retire count
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state         <= S_RESET;
      wait_cnt      <= '0;
      mem_err       <= 1'b0;
      stop_q        <= 1'b0;
      instr_retired <= '0;
    end else begin
      state <= next;
      if (mem_wait && !mem_ready && !timeout)
        wait_cnt <= wait_cnt + CW'(1);
      else
        wait_cnt <= '0;
      if (timeout)
        mem_err <= 1'b1;
      stop_q <= run && (stop || stop_q)
             && (next != S_T0)
             && (next != S_HALT);
      if (retire)
        instr_retired <= instr_retired
                       + DATA_W'(1);
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random instruction stream
// checked against a micro-program table model
module tb_control_sequencer;

  localparam int DATA_W   = 32;
  localparam int OPCODE_W = 5;
  localparam int WAIT_MAX = 15;

  localparam logic [24:0] M_PCOUT  = 25'b1 << 24;
  localparam logic [24:0] M_MARIN  = 25'b1 << 23;
  localparam logic [24:0] M_MDRIN  = 25'b1 << 22;
  localparam logic [24:0] M_READ   = 25'b1 << 21;
  localparam logic [24:0] M_WRITE  = 25'b1 << 20;
  localparam logic [24:0] M_MDROUT = 25'b1 << 19;
  localparam logic [24:0] M_IRIN   = 25'b1 << 18;
  localparam logic [24:0] M_PCIN   = 25'b1 << 17;
  localparam logic [24:0] M_INCPC  = 25'b1 << 16;
  localparam logic [24:0] M_GRA    = 25'b1 << 15;
  localparam logic [24:0] M_GRB    = 25'b1 << 14;
  localparam logic [24:0] M_GRC    = 25'b1 << 13;
  localparam logic [24:0] M_RIN    = 25'b1 << 12;
  localparam logic [24:0] M_ROUT   = 25'b1 << 11;
  localparam logic [24:0] M_BAOUT  = 25'b1 << 10;
  localparam logic [24:0] M_YIN    = 25'b1 << 9;
  localparam logic [24:0] M_ZIN    = 25'b1 << 8;
  localparam logic [24:0] M_ZLOW   = 25'b1 << 7;
  localparam logic [24:0] M_ZHIGH  = 25'b1 << 6;
  localparam logic [24:0] M_COUT   = 25'b1 << 5;
  localparam logic [24:0] M_HIIN   = 25'b1 << 4;
  localparam logic [24:0] M_LOIN   = 25'b1 << 3;
  localparam logic [24:0] M_CONIN  = 25'b1 << 2;
  localparam logic [24:0] M_INPORT = 25'b1 << 1;
  localparam logic [24:0] M_OUTPRT = 25'b1;

  logic Clock;
  logic clear;
  logic [DATA_W-1:0] IR;
  logic CON_FF, mem_ready, start, stop;
  logic PCout, MARin, MDRin, Read, Write;
  logic MDRout, IRin, PCin, IncPC, Gra;
  logic Grb, Grc, Rin, Rout, BAout;
  logic Yin, Zin, Zlowout, Zhighout, Cout;
  logic HIin, LOin, CONin, Inportout, Outportin;
  logic [OPCODE_W-1:0] opcode;
  logic run, illegal, mem_err;
  logic [DATA_W-1:0] instr_retired;
  logic [24:0] strobes;

  assign strobes = {PCout, MARin, MDRin, Read,
    Write, MDRout, IRin, PCin, IncPC, Gra,
    Grb, Grc, Rin, Rout, BAout, Yin, Zin,
    Zlowout, Zhighout, Cout, HIin, LOin,
    CONin, Inportout, Outportin};

  control_sequencer #(
    .DATA_W  (DATA_W),
    .OPCODE_W(OPCODE_W),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .Clock(Clock), .clear(clear), .IR(IR),
    .CON_FF(CON_FF), .mem_ready(mem_ready),
    .start(start), .stop(stop),
    .PCout(PCout), .MARin(MARin),
    .MDRin(MDRin), .Read(Read),
    .Write(Write), .MDRout(MDRout),
    .IRin(IRin), .PCin(PCin),
    .IncPC(IncPC), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout),
    .Cout(Cout), .HIin(HIin), .LOin(LOin),
    .CONin(CONin), .Inportout(Inportout),
    .Outportin(Outportin), .opcode(opcode),
    .run(run), .illegal(illegal),
    .mem_err(mem_err),
    .instr_retired(instr_retired)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_ret = '0;
  bit exp_err = 1'b0;
  bit halted = 1'b0;
  logic [24:0] pm [8];
  logic [24:0] px [8];
  bit pw [8];
  int np;
  logic [31:0] ld_ir;

  task automatic check(input string tag,
    input logic [31:0] got,
    input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t",
        tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] ir,
    input bit con, input bit rdy,
    input bit stp, input bit stt);
    IR = ir;
    CON_FF = con;
    mem_ready = rdy;
    stop = stp;
    start = stt;
  endtask

  // compare one cycle, then move to next negedge
  task automatic step(input logic [24:0] em,
    input logic [4:0] eop, input bit erun,
    input bit eill);
    #1;
    check("strobes", 32'(strobes), 32'(em));
    check("opcode", 32'(opcode), 32'(eop));
    check("run", 32'(run), 32'(erun));
    check("illegal", 32'(illegal), 32'(eill));
    check("mem_err", 32'(mem_err), 32'(exp_err));
    check("retired", instr_retired, exp_ret);
    @(negedge Clock);
  endtask

  // micro-program table: one entry per T-step
  task automatic build(input logic [4:0] op,
    input bit con);
    for (int i = 0; i < 8; i++) begin
      pm[i] = '0; px[i] = '0; pw[i] = 1'b0;
    end
    pm[0] = M_PCOUT | M_MARIN;
    pm[1] = M_READ | M_MDRIN;
    pw[1] = 1'b1;
    px[1] = M_PCIN | M_INCPC;
    pm[2] = M_MDROUT | M_IRIN;
    np = 3;
    if (op <= 5'd13) begin
      pm[3] = M_GRB | M_ROUT | M_YIN;
      pm[4] = (op <= 5'd10)
        ? (M_GRC | M_ROUT | M_ZIN)
        : (M_COUT | M_ZIN);
      pm[5] = M_ZLOW | M_GRA | M_RIN;
      np = 6;
    end else if (op == 5'd14 || op == 5'd15) begin
      pm[3] = M_GRB | M_BAOUT | M_YIN;
      pm[4] = M_COUT | M_ZIN;
      pm[5] = M_ZLOW | M_MARIN;
      if (op == 5'd14) begin
        pm[6] = M_READ | M_MDRIN;
        pw[6] = 1'b1;
        pm[7] = M_MDROUT | M_GRA | M_RIN;
      end else begin
        pm[6] = M_GRA | M_ROUT | M_MDRIN;
        pm[7] = M_WRITE;
        pw[7] = 1'b1;
      end
      np = 8;
    end else if (op == 5'd16 || op == 5'd17) begin
      pm[3] = M_GRA | M_ROUT | M_YIN;
      pm[4] = M_GRB | M_ROUT | M_ZIN;
      pm[5] = M_ZLOW | M_LOIN;
      pm[6] = M_ZHIGH | M_HIIN;
      np = 7;
    end else if (op == 5'd18) begin
      pm[3] = M_GRA | M_ROUT | M_CONIN;
      pm[4] = M_PCOUT | M_YIN;
      pm[5] = M_COUT | M_ZIN;
      pm[6] = con ? (M_ZLOW | M_PCIN) : 25'b0;
      np = 7;
    end else if (op == 5'd19) begin
      pm[3] = M_GRA | M_ROUT | M_PCIN; np = 4;
    end else if (op == 5'd20) begin
      pm[3] = M_INPORT | M_GRA | M_RIN; np = 4;
    end else if (op == 5'd21) begin
      pm[3] = M_GRA | M_ROUT | M_OUTPRT; np = 4;
    end
  endtask

  // dly: cycles mem_ready stays low per wait step
  task automatic run_instr(input logic [31:0] ir,
    input bit con, input int dly,
    input int stop_at);
    logic [4:0] op;
    bit ill, alu, seen, to, rdy, stp;
    int c;
    int waits;
    logic [24:0] em;
    op = ir[31:27];
    ill = (op >= 5'd24);
    alu = (op <= 5'd13) || (op == 5'd16)
       || (op == 5'd17);
    build(op, con);
    seen = 1'b0; to = 1'b0; c = 0;
    for (int s = 0; s < np && !to; s++) begin
      waits = pw[s] ? dly : 0;
      for (int k = 0; k <= waits; k++) begin
        rdy = pw[s] ? (k >= dly) : 1'($urandom);
        stp = (c == stop_at);
        seen = seen | stp;
        drive(ir, con, rdy, stp, 1'($urandom));
        em = pm[s] | ((pw[s] && rdy) ? px[s] : 25'b0);
        step(em, (s >= 3 && alu) ? op : 5'd0,
          1'b1, ill && (s == 2));
        c++;
        if (pw[s] && !rdy && k == WAIT_MAX - 1) begin
          to = 1'b1;
          break;
        end
      end
    end
    if (to) begin
      exp_err = 1'b1;
      halted = 1'b1;
    end else begin
      if (!ill) exp_ret = exp_ret + 32'd1;
      if (op == 5'd23 || seen) halted = 1'b1;
    end
  endtask

  // sit in HALT, check stop+start holds, then start
  task automatic do_halt(input int idle);
    for (int i = 0; i < idle; i++) begin
      drive($urandom, 1'($urandom), 1'($urandom),
        1'($urandom), 1'b0);
      step(25'b0, 5'd0, 1'b0, 1'b0);
    end
    drive($urandom, 1'b0, 1'b0, 1'b1, 1'b1);
    step(25'b0, 5'd0, 1'b0, 1'b0);
    drive($urandom, 1'b0, 1'b0, 1'b0, 1'b1);
    step(25'b0, 5'd0, 1'b0, 1'b0);
    halted = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    int dly, sa;
    clear = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge Clock);
    step(25'b0, 5'd0, 1'b0, 1'b0);
    clear = 1'b1;
    step(25'b0, 5'd0, 1'b0, 1'b0);

    // LD up to its T6 wait, then async reset
    build(5'd14, 1'b0);
    ld_ir = {5'd14, 27'h0123456};
    for (int s = 0; s < 7; s++) begin
      drive(ld_ir, 1'b0, s != 6, 1'b0, 1'b0);
      step(pm[s] | ((s != 6) ? px[s] : 25'b0),
        5'd0, 1'b1, 1'b0);
    end
    #3 clear = 1'b0;
    #1;
    check("rst_strobes", 32'(strobes), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_retired", instr_retired, exp_ret);
    @(negedge Clock);
    clear = 1'b1;
    step(25'b0, 5'd0, 1'b0, 1'b0);

    run_instr(32'h5908_0002, 1'b0, 0, -1);
    run_instr(32'h5908_0002, 1'b1, 3, -1);
    run_instr({5'd18, 27'h55}, 1'b1, 0, -1);
    run_instr({5'd18, 27'h55}, 1'b0, 0, -1);
    run_instr({5'd31, 27'h7}, 1'b0, 0, -1);
    run_instr({5'd1, 27'h9}, 1'b0, 0, 4);
    if (halted) do_halt(1);
    else check("stop_halt", 32'(halted), 32'd1);
    run_instr({5'd23, 27'h0}, 1'b0, 0, -1);
    if (halted) do_halt(2);
    run_instr({5'd15, 27'h3}, 1'b0, 2, -1);

    for (int n = 0; n < 300; n++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0)
        dly = WAIT_MAX;
      else if ($urandom_range(0, 3) == 0)
        dly = int'($urandom_range(1, 3));
      else
        dly = 0;
      if ($urandom_range(0, 14) == 0)
        sa = int'($urandom_range(0, 7));
      else
        sa = -1;
      run_instr({op, 27'($urandom)},
        1'($urandom), dly, sa);
      if (halted) do_halt(int'($urandom_range(0, 2)));
    end

    run_instr(32'h5908_0002, 1'b0, WAIT_MAX, -1);
    if (halted) do_halt(1);
    else check("timeout_halt", 32'(halted), 32'd1);
    run_instr(32'h5908_0002, 1'b0, 0, -1);
    step(M_PCOUT | M_MARIN, 5'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
